nihilist_stream_decryptor: RTL



---
 rtl/nihilist_pkg.sv | 40 ++++
 rtl/nihilist_stream_decryptor_polybius_lookup.sv | 23 ++
 rtl/nihilist_stream_decryptor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nihilist_pkg.sv
// Shared constants, helpers and FSM state type for the Nihilist cipher blocks:
// the 5x5 Polybius table (J omitted), the fixed key "NEDELCU" and its codes.
package nihilist_pkg;

    localparam int          SEC_LEN_MAX = 7;
    localparam logic [7:0]  ERR_CHAR    = 8'h3F;

    localparam logic [8*25-1:0]          POLY_TABLE = "RAESBCDFGHIKLMNOPQTUVWXYZ";
    localparam logic [8*SEC_LEN_MAX-1:0] KEY_STR    = "NEDELCU";

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} nihilist_state_e;

    // Table entries are stored first-letter-in-MSB, so index 0 is the top byte.
    function automatic logic [7:0] poly_char(input logic [4:0] idx);
        return POLY_TABLE[8*(24-int'(idx)) +: 8];
    endfunction

    function automatic logic [6:0] char_to_code(input logic [7:0] c);
        logic [6:0] code;
        code = '0;
        for (int i = 0; i < 25; i++) begin
            if (poly_char(5'(i)) == c) begin
                code = 7'((i / 5 + 1) * 10 + (i % 5) + 1);
            end
        end
        return code;
    endfunction

    function automatic logic [7:0] key_char(input int k);
        return KEY_STR[8*(SEC_LEN_MAX-1-k) +: 8];
    endfunction

    localparam logic [6:0] KEY_CODES [SEC_LEN_MAX] = '{
        char_to_code(key_char(0)), char_to_code(key_char(1)),
        char_to_code(key_char(2)), char_to_code(key_char(3)),
        char_to_code(key_char(4)), char_to_code(key_char(5)),
        char_to_code(key_char(6))
    };

endpackage

// File: rtl/nihilist_stream_decryptor_polybius_lookup.sv
// Combinational Polybius lookup: (row, col) in 1..5 to the table letter,
// flagging coordinates outside the 5x5 grid.
module polybius_lookup
    import nihilist_pkg::*;
(
    input  logic [2:0] row_i,
    input  logic [2:0] col_i,
    output logic [7:0] char_o,
    output logic       err_o
);

    logic [4:0] idx;

    always_comb begin
        err_o  = (row_i == 3'd0) || (row_i > 3'd5) || (col_i == 3'd0) || (col_i > 3'd5);
        idx    = ({2'b00, row_i} - 5'd1) * 5'd5 + {2'b00, col_i} - 5'd1;
        char_o = ERR_CHAR;
        if (!err_o) begin
            char_o = poly_char(idx);
        end
    end

endmodule

// File: rtl/nihilist_stream_decryptor.sv
// Two-stage valid/ready Nihilist decryptor framed by an IDLE/LOAD/DRAIN FSM.
// Optional macro NIHILIST_DEC_ERR_CNT_EN adds err_count and msg_err outputs.
module nihilist_stream_decryptor
    import nihilist_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       msg_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_char,
    output logic       out_err,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
`ifdef NIHILIST_DEC_ERR_CNT_EN
    output logic [7:0] err_count,
    output logic       msg_err,
`endif
    output logic       done
);

    localparam int             CW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(MSG_LEN - 1);
    localparam logic [2:0]     KEY_LAST = 3'(SEC_LEN - 1);

    nihilist_state_e state_q, state_d;
    logic [2:0]      keyIdx_q, keyIdx_d;
    logic [CW-1:0]   inCnt_q, inCnt_d;

    logic            s1Valid_q, s1Err_q, s1Last_q;
    logic [2:0]      s1Row_q, s1Col_q;
    logic            outValid_q, outErr_q, outLast_q, done_q;
    logic [7:0]      outChar_q;

    logic            inFire, outFire, lastFire, msgAccept, s1Load, s2Load;
    logic signed [8:0] diff, base, colFull;
    logic [2:0]      row1;
    logic            err1;
    logic [7:0]      lkChar;
    logic            lkErr;

    assign s2Load    = !outValid_q || out_ready;
    assign s1Load    = !s1Valid_q || s2Load;
    assign inFire    = in_valid && in_ready;
    assign outFire   = outValid_q && out_ready;
    assign lastFire  = outFire && outLast_q;
    assign msgAccept = (state_q == IDLE) && msg_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (msg_start) state_d = LOAD;
            LOAD:    if (inFire && (inCnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (lastFire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD) && s1Load;
        busy     = (state_q != IDLE);
    end

    always_comb begin
        keyIdx_d = keyIdx_q;
        inCnt_d  = inCnt_q;
        if (msgAccept) begin
            keyIdx_d = '0;
            inCnt_d  = '0;
        end else if (inFire) begin
            keyIdx_d = (keyIdx_q == KEY_LAST) ? 3'd0 : keyIdx_q + 3'd1;
            inCnt_d  = inCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyIdx_q <= '0;
            inCnt_q  <= '0;
        end else begin
            keyIdx_q <= keyIdx_d;
            inCnt_q  <= inCnt_d;
        end
    end

    // Tens digit by a compare chain; anything outside 11..55 is flagged anyway.
    always_comb begin
        diff = $signed({1'b0, in_data}) - $signed({2'b00, KEY_CODES[keyIdx_q]});
        if      (diff >= 9'sd50) begin row1 = 3'd5; base = 9'sd50; end
        else if (diff >= 9'sd40) begin row1 = 3'd4; base = 9'sd40; end
        else if (diff >= 9'sd30) begin row1 = 3'd3; base = 9'sd30; end
        else if (diff >= 9'sd20) begin row1 = 3'd2; base = 9'sd20; end
        else if (diff >= 9'sd10) begin row1 = 3'd1; base = 9'sd10; end
        else                     begin row1 = 3'd0; base = 9'sd0;  end
        colFull = diff - base;
        err1    = (diff < 9'sd11) || (diff > 9'sd55) ||
                  (colFull == 9'sd0) || (colFull > 9'sd5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Row_q   <= '0;
            s1Col_q   <= '0;
            s1Err_q   <= 1'b0;
            s1Last_q  <= 1'b0;
        end else if (s1Load) begin
            s1Valid_q <= inFire;
            if (inFire) begin
                s1Row_q  <= row1;
                s1Col_q  <= colFull[2:0];
                s1Err_q  <= err1;
                s1Last_q <= (inCnt_q == LAST_IDX);
            end
        end
    end

    polybius_lookup u_lookup (
        .row_i  (s1Row_q),
        .col_i  (s1Col_q),
        .char_o (lkChar),
        .err_o  (lkErr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outChar_q  <= 8'h00;
            outErr_q   <= 1'b0;
            outLast_q  <= 1'b0;
        end else if (s2Load) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outChar_q <= (s1Err_q || lkErr) ? ERR_CHAR : lkChar;
                outErr_q  <= s1Err_q || lkErr;
                outLast_q <= s1Last_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state_q == DRAIN) && lastFire;
    end

    assign out_valid = outValid_q;
    assign out_char  = outChar_q;
    assign out_err   = outErr_q;
    assign out_last  = outLast_q;
    assign done      = done_q;

`ifdef NIHILIST_DEC_ERR_CNT_EN
    logic [7:0] errCount_q, errCount_d;
    logic       msgErr_q, msgErr_d;

    // Counter survives done so the sink can read it until the next message.
    always_comb begin
        errCount_d = errCount_q;
        msgErr_d   = msgErr_q;
        if (msgAccept) begin
            errCount_d = '0;
            msgErr_d   = 1'b0;
        end else begin
            if (outFire && outErr_q && (errCount_q != 8'hFF)) begin
                errCount_d = errCount_q + 8'd1;
            end
            if ((state_q == DRAIN) && lastFire) begin
                msgErr_d = (errCount_d != 8'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCount_q <= '0;
            msgErr_q   <= 1'b0;
        end else begin
            errCount_q <= errCount_d;
            msgErr_q   <= msgErr_d;
        end
    end

    assign err_count = errCount_q;
    assign msg_err   = msgErr_q;
`endif

endmodule
